// File: rtl/gsm_multi_dialer.sv
// gsm_multi_dialer: debounces NUM_CONTACTS call keys plus a hang-up key,
// arbitrates between them and streams "ATD<number>;\r\n" or "ATH\r\n"
// as 8N1 UART frames to the GSM module.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for a debounced key request
// LOAD  | fetch the current command byte, reset the bit timer
// START | start bit (low) for BIT_CYC cycles
// DATA  | 8 data bits, LSB first, BIT_CYC cycles each
// STOP  | stop bit (high); then next byte's START or DONE after the last
// DONE  | one-cycle done pulse, busy low, then back to IDLE
module gsm_multi_dialer #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int NUM_CONTACTS = 2,
  parameter int NUM_DIGITS   = 11,
  parameter logic [NUM_CONTACTS*NUM_DIGITS*8-1:0] PHONE_BOOK = {NUM_CONTACTS*NUM_DIGITS{8'h30}},
  parameter int DEBOUNCE_CYC = 1_000_000,
  localparam int AW = (NUM_CONTACTS > 1) ? $clog2(NUM_CONTACTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CONTACTS-1:0] call_key_n,
  input  logic                    hangup_key_n,
  output logic                    calling_tx,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           active_contact,
  output logic                    is_hangup
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int TW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int DBW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int IDXW    = $clog2(NUM_DIGITS + 6);
  localparam int NK      = NUM_CONTACTS + 1;
  localparam int HUP     = NUM_CONTACTS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [NK-1:0]   raw_keys;
  logic [NK-1:0]   sync1;
  logic [NK-1:0]   sync2;
  logic [1:0]      sync_ready;
  logic [NK-1:0]   deb;
  logic [NK-1:0]   armed;
  logic [NK-1:0]   req;
  logic [DBW-1:0]  deb_cnt [NK];

  logic [2:0]      state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_cnt;
  logic [IDXW-1:0] byte_idx;
  logic            last_byte;
  logic [7:0]      shreg;
  logic [7:0]      byte_val;
  logic [IDXW-1:0] last_idx;
  logic [NUM_DIGITS*8-1:0] number;
  logic            call_hit;
  logic [AW-1:0]   call_idx;

  assign raw_keys = {hangup_key_n, call_key_n};

  // Two-flop synchronisers; sync_ready marks when sync2 reflects real pins
  // after reset so a key held through reset cannot look released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '1;
      sync2      <= '1;
      sync_ready <= 2'b00;
    end else begin
      sync1      <= raw_keys;
      sync2      <= sync1;
      sync_ready <= {sync_ready[0], 1'b1};
    end
  end

  // Per-key debounce; a press request needs the key to have been seen
  // released (armed) since reset, and fires once on the debounced fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb   <= '1;
      armed <= '0;
      req   <= '0;
      for (int k = 0; k < NK; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        req[k] <= 1'b0;
        if (sync_ready[1] && sync2[k] && deb[k]) armed[k] <= 1'b1;
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DBW'(DEBOUNCE_CYC - 1)) begin
          deb_cnt[k] <= '0;
          deb[k]     <= sync2[k];
          req[k]     <= armed[k] & ~sync2[k];
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Lowest-index call request wins.
  always_comb begin
    call_hit = 1'b0;
    call_idx = '0;
    for (int k = NUM_CONTACTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        call_hit = 1'b1;
        call_idx = AW'(k);
      end
    end
  end

  // Command byte lookup for the current byte index.
  always_comb begin
    number = '0;
    for (int k = 0; k < NUM_CONTACTS; k++) begin
      if (active_contact == AW'(k)) number = PHONE_BOOK[k*NUM_DIGITS*8 +: NUM_DIGITS*8];
    end
    last_idx = is_hangup ? IDXW'(4) : IDXW'(NUM_DIGITS + 5);
    byte_val = 8'h00;
    if (byte_idx == IDXW'(0)) begin
      byte_val = 8'h41;
    end else if (byte_idx == IDXW'(1)) begin
      byte_val = 8'h54;
    end else if (is_hangup) begin
      if (byte_idx == IDXW'(2)) byte_val = 8'h48;
      else if (byte_idx == IDXW'(3)) byte_val = 8'h0D;
      else if (byte_idx == IDXW'(4)) byte_val = 8'h0A;
    end else begin
      if (byte_idx == IDXW'(2)) byte_val = 8'h44;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (byte_idx == IDXW'(d + 3)) byte_val = number[(NUM_DIGITS-1-d)*8 +: 8];
      end
      if (byte_idx == IDXW'(NUM_DIGITS + 3)) byte_val = 8'h3B;
      else if (byte_idx == IDXW'(NUM_DIGITS + 4)) byte_val = 8'h0D;
      else if (byte_idx == IDXW'(NUM_DIGITS + 5)) byte_val = 8'h0A;
    end
  end

  // Sequencer: arbitration, bit timing and the registered TX line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      calling_tx     <= 1'b1;
      timer          <= '0;
      bit_cnt        <= '0;
      byte_idx       <= '0;
      last_byte      <= 1'b0;
      shreg          <= '0;
      active_contact <= '0;
      is_hangup      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          calling_tx <= 1'b1;
          if (req[HUP]) begin
            is_hangup <= 1'b1;
            byte_idx  <= '0;
            state     <= S_LOAD;
          end else if (call_hit) begin
            is_hangup      <= 1'b0;
            active_contact <= call_idx;
            byte_idx       <= '0;
            state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg      <= byte_val;
          timer      <= TW'(BIT_CYC - 1);
          calling_tx <= 1'b0;
          state      <= S_START;
        end
        S_START: begin
          if (timer == '0) begin
            timer      <= TW'(BIT_CYC - 1);
            calling_tx <= shreg[0];
            shreg      <= {1'b0, shreg[7:1]};
            bit_cnt    <= '0;
            state      <= S_DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DATA: begin
          if (timer == '0) begin
            timer <= TW'(BIT_CYC - 1);
            if (bit_cnt == 3'd7) begin
              calling_tx <= 1'b1;
              last_byte  <= (byte_idx == last_idx);
              byte_idx   <= byte_idx + 1'b1;
              state      <= S_STOP;
            end else begin
              calling_tx <= shreg[0];
              shreg      <= {1'b0, shreg[7:1]};
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_STOP: begin
          if (timer == '0) begin
            if (last_byte) begin
              is_hangup <= 1'b0;
              state     <= S_DONE;
            end else begin
              timer      <= TW'(BIT_CYC - 1);
              shreg      <= byte_val;
              calling_tx <= 1'b0;
              state      <= S_START;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE: begin
          calling_tx <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          calling_tx <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_LOAD) || (state == S_START) || (state == S_DATA) || (state == S_STOP);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_gsm_multi_dialer.sv
module tb_gsm_multi_dialer;

  localparam int  BIT = 10;
  localparam int  LAT = 8;   // input change -> start edge: 2 sync + 4 debounce + request + LOAD
  localparam logic [47:0] PB = {"120", "110"};
  localparam int  LINE_MAX = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] call_key_n;
  logic       hangup_key_n;
  logic       calling_tx, busy, done, is_hangup;
  logic [0:0] active_contact;

  gsm_multi_dialer #(
    .CLK_FREQ(1000), .BAUD(100), .NUM_CONTACTS(2), .NUM_DIGITS(3),
    .PHONE_BOOK(PB), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .call_key_n(call_key_n), .hangup_key_n(hangup_key_n),
    .calling_tx(calling_tx), .busy(busy), .done(done),
    .active_contact(active_contact), .is_hangup(is_hangup)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state
  string      num [2] = '{"110", "120"};
  logic [7:0] exp_q [$];
  logic [7:0] lit_q [$];
  bit         fs_valid = 0;
  int         fs = 0;
  bit         exp_hang = 0;
  int         exp_ac = 0;
  int         t_start = -1, t_done = -1, done_cnt = 0;
  logic       line_s [0:LINE_MAX-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void start_frame(input bit hang, input int k);
    string s;
    s = hang ? "ATH" : {"ATD", num[k], ";"};
    exp_q = {};
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_hang = hang;
    if (!hang) exp_ac = k;
    fs       = cyc + LAT;
    fs_valid = 1;
    t_start  = -1;
    t_done   = -1;
    done_cnt = 0;
  endfunction

  // Compare process: every cycle, outputs against the frame model.
  initial begin
    int rel, nb, pos;
    logic e_tx, e_busy, e_done, e_hang;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc < LINE_MAX) line_s[cyc] = calling_tx;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_hang = 1'b0;
      if (!rst_n) begin
        fs_valid = 0;
        chk("rst_ac", {31'd0, active_contact}, 0);
      end else if (fs_valid) begin
        rel = cyc - fs;
        nb  = exp_q.size();
        if (rel == -1) begin
          e_busy = 1'b1; e_hang = exp_hang;
        end else if (rel >= 0 && rel < nb*10*BIT) begin
          b   = exp_q[rel / (10*BIT)];
          pos = (rel % (10*BIT)) / BIT;
          e_tx   = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos-1];
          e_busy = 1'b1;
          e_hang = exp_hang;
        end else if (rel == nb*10*BIT) begin
          e_done = 1'b1;
        end
        if (rel >= -1 && rel <= nb*10*BIT && !exp_hang)
          chk("active_contact", {31'd0, active_contact}, exp_ac);
      end
      chk("calling_tx", {31'd0, calling_tx}, {31'd0, e_tx});
      chk("busy",       {31'd0, busy},       {31'd0, e_busy});
      chk("done",       {31'd0, done},       {31'd0, e_done});
      chk("is_hangup",  {31'd0, is_hangup},  {31'd0, e_hang});
      if (rst_n && calling_tx === 1'b0 && t_start < 0) t_start = cyc;
      if (rst_n && done === 1'b1) begin
        t_done = cyc;
        done_cnt++;
      end
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to_end(input int extra);
    int lim;
    lim = fs + exp_q.size()*10*BIT + extra;
    while (cyc < lim) at_neg();
  endtask

  task automatic decode_check(input string nm);
    logic [7:0] v;
    for (int j = 0; j < lit_q.size(); j++) begin
      for (int i = 0; i < 8; i++) v[i] = line_s[fs + j*10*BIT + BIT*(i+1) + BIT/2];
      chk(nm, {24'd0, v}, {24'd0, lit_q[j]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    call_key_n = 2'b11;
    hangup_key_n = 1'b1;

    // reset held with keys toggling
    for (int i = 0; i < 12; i++) begin
      at_neg();
      call_key_n   = 2'($urandom_range(0, 3));
      hangup_key_n = 1'($urandom_range(0, 1));
    end
    at_neg(); call_key_n = 2'b11; hangup_key_n = 1'b1;
    at_neg(); at_neg();
    rst_n = 1'b1;
    repeat (12) at_neg();

    // contact 1, held 50 cycles
    at_neg(); call_key_n[1] = 1'b0; start_frame(0, 1);
    repeat (50) at_neg();
    call_key_n[1] = 1'b1;
    run_to_end(20);
    lit_q = '{8'h41, 8'h54, 8'h44, 8'h31, 8'h32, 8'h30, 8'h3B, 8'h0D, 8'h0A};
    decode_check("c1_byte");
    chk("c1_frame_len", t_done - t_start, 900);
    chk("c1_done_cnt", done_cnt, 1);

    // both call keys on the same cycle
    at_neg(); call_key_n = 2'b00; start_frame(0, 0);
    repeat (30) at_neg();
    call_key_n = 2'b11;
    run_to_end(150);
    lit_q = '{8'h41, 8'h54, 8'h44, 8'h31, 8'h31, 8'h30, 8'h3B, 8'h0D, 8'h0A};
    decode_check("both_byte");
    chk("both_done_cnt", done_cnt, 1);

    // hang-up together with call key 0
    at_neg(); hangup_key_n = 1'b0; call_key_n[0] = 1'b0; start_frame(1, 0);
    repeat (30) at_neg();
    hangup_key_n = 1'b1; call_key_n[0] = 1'b1;
    run_to_end(150);
    lit_q = '{8'h41, 8'h54, 8'h48, 8'h0D, 8'h0A};
    decode_check("hup_byte");
    chk("hup_frame_len", t_done - t_start, 500);
    chk("hup_done_cnt", done_cnt, 1);

    // 2-cycle glitch, then a press during a frame
    at_neg(); call_key_n[0] = 1'b0;
    at_neg(); at_neg(); call_key_n[0] = 1'b1;
    repeat (40) at_neg();
    at_neg(); call_key_n[1] = 1'b0; start_frame(0, 1);
    repeat (50) at_neg();
    call_key_n[1] = 1'b1;
    while (cyc < fs + 200) at_neg();
    call_key_n[0] = 1'b0;
    repeat (40) at_neg();
    call_key_n[0] = 1'b1;
    run_to_end(150);
    chk("glitch_done_cnt", done_cnt, 1);
    chk("glitch_frame_len", t_done - t_start, 900);

    // reset during byte 3, key 0 held through reset release
    at_neg(); call_key_n[0] = 1'b0; start_frame(0, 0);
    while (cyc < fs + 3*10*BIT + 25) at_neg();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_now", {31'd0, calling_tx}, 1);
    chk("rst_busy_now", {31'd0, busy}, 0);
    repeat (5) at_neg();
    rst_n = 1'b1;
    repeat (40) at_neg();
    call_key_n[0] = 1'b1;
    repeat (20) at_neg();
    at_neg(); call_key_n[1] = 1'b0; start_frame(0, 1);
    repeat (50) at_neg();
    call_key_n[1] = 1'b1;
    run_to_end(30);
    lit_q = '{8'h41, 8'h54, 8'h44, 8'h31, 8'h32, 8'h30, 8'h3B, 8'h0D, 8'h0A};
    decode_check("post_rst_byte");
    chk("post_rst_frame_len", t_done - t_start, 900);
    chk("post_rst_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsm_multi_dialer.md
Name: gsm_multi_dialer

Overview:
Parametrised GSM emergency dialer. Debounces NUM_CONTACTS active-low call keys and one hang-up key, arbitrates between them, and serialises "ATD<number>;\r\n" or "ATH\r\n" onto a single 8N1 UART line to the GSM module. The block owns its own baud timing and byte sequencing, and replaces the fixed two-contact calling/bps/sender trio at the top level.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz
BAUD, 9600, UART bit rate; BIT_CYC = CLK_FREQ/BAUD (integer division)
NUM_CONTACTS, 2, number of call keys/phone numbers (1..8)
NUM_DIGITS, 11, ASCII digits per phone number
PHONE_BOOK, all ASCII '0', NUM_CONTACTS*NUM_DIGITS*8 bits; contact k occupies bits [(k+1)*NUM_DIGITS*8-1 : k*NUM_DIGITS*8]; first digit sent is the most significant byte of the slice
DEBOUNCE_CYC, 1_000_000, cycles a synchronised key must be stable before its level is accepted

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
call_key_n  in  NUM_CONTACTS  raw call keys, low = pressed, asynchronous
hangup_key_n  in  1  raw hang-up key, low = pressed, asynchronous
calling_tx  out  1  UART TX to GSM module, idle high
busy  out  1  high while a command is being transmitted
done  out  1  one-cycle pulse when the last stop bit of a command has completed
active_contact  out  max(1,clog2(NUM_CONTACTS))  index of the contact being dialled; valid while busy and is_hangup=0
is_hangup  out  1  high while busy with "ATH\r\n"

Behaviour:
- Reset (asynchronous, active-low): calling_tx=1, busy=0, done=0, active_contact=0, is_hangup=0. Synchroniser and debounced levels reset to 1 (released), debounce counters to 0, FSM to IDLE. Asserting reset mid-frame aborts immediately; the line returns high at once.
- Key path, per key: 2-flop synchroniser, then debounce. Counter clears whenever the synchronised level equals the debounced level; otherwise it increments, and the debounced level flips when the count reaches DEBOUNCE_CYC-1. A press request is a one-cycle pulse on a debounced 1->0 transition. A held key gives exactly one request; a new request needs release and re-press. A key held low through reset release gives no request until it is released and pressed again.
- Arbitration, in IDLE only: a hang-up request beats any call request in the same cycle. Among call requests, the lowest index wins. Requests arriving while busy=1 are dropped, not queued.
- Frame content:
  - Call: 'A','T','D', NUM_DIGITS digits, ';', 0x0D, 0x0A. Total NUM_DIGITS+6 bytes.
  - Hang-up: 'A','T','H', 0x0D, 0x0A. Total 5 bytes.
  - Byte selection uses a byte index counter wide enough for NUM_DIGITS+6.
- FSM states: IDLE, LOAD, START, DATA, STOP, DONE.
  - IDLE -> LOAD on an accepted request at cycle t. busy, active_contact and is_hangup are registered at t+1.
  - LOAD fetches the byte and resets the bit timer. START is entered at t+2, and calling_tx goes low at t+2.
  - START, each DATA bit (LSB first, 8 bits) and STOP are each held exactly BIT_CYC cycles.
  - STOP -> START for the next byte with no idle gap. After the last byte's STOP, go to DONE.
  - DONE: done=1 and busy=0 for one cycle. active_contact holds its value; is_hangup clears. Then return to IDLE.
- A frame of B bytes occupies exactly B*10*BIT_CYC cycles from the first start edge to the cycle before done.
- calling_tx is registered and glitch-free. It is high in IDLE, LOAD and DONE.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=1000, BAUD=100 (BIT_CYC=10), DEBOUNCE_CYC=4, NUM_CONTACTS=2, NUM_DIGITS=3, PHONE_BOOK contact0="110", contact1="120".
- Reset: hold rst_n=0 with keys toggling -> calling_tx=1, busy=0, done=0 throughout.
- Press call_key_n[1] for 50 cycles -> bytes 0x41 0x54 0x44 0x31 0x32 0x30 0x3B 0x0D 0x0A decoded at 10 cycles/bit. busy high for 900 line cycles, active_contact=1, then a single done pulse.
- Both call keys pressed on the same cycle -> contact0 dialled ("ATD110;\r\n"). No second frame follows.
- Hang-up and call_key_n[0] pressed together -> "ATH\r\n" (0x41 0x54 0x48 0x0D 0x0A), is_hangup=1, and the call request is dropped.
- 2-cycle glitch on call_key_n[0], then a press during a frame -> no frame for the glitch; the press during busy is ignored.
- Assert rst_n during the 4th byte -> calling_tx high within the reset cycle. After release the block is idle and a new press produces a complete frame.
